bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_rd_pkg.sv | 19 +
 rtl/bram_rd_skid.sv | 53 +++++
 rtl/bram_stream_reader.sv | 142 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM stream reader: FSM encoding and word sizing.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_BW = 32;

    // Byte stride between consecutive words for a given word width.
    function automatic int bytes_per_word(input int data_bw);
        return data_bw / 8;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(DEFAULT_DATA_BW);

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry FIFO between the memory read port and the stream output.
// Supports a push and a pop in the same cycle; head is held stable until popped.
module bram_rd_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = i_pop && o_valid;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads i_len consecutive words from a 1-cycle-latency BRAM and streams them out.
// Optional BRAM_RD_TLAST_EN adds m_axis_tlast on the final beat.
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int ADDR_BW = 10,
    parameter int DATA_BW = 32,
    parameter int LEN_BW  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [ADDR_BW-1:0] i_base_addr,
    input  logic [LEN_BW-1:0]  i_len,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_r_en,
    output logic [ADDR_BW-1:0] o_r_addr,
    input  logic [DATA_BW-1:0] i_r_data,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [DATA_BW-1:0] m_axis_tdata
`ifdef BRAM_RD_TLAST_EN
   ,output logic               m_axis_tlast
`endif
);

    localparam int STRIDE = bytes_per_word(DATA_BW);
`ifdef BRAM_RD_TLAST_EN
    localparam int FIFO_W = DATA_BW + 1;
`else
    localparam int FIFO_W = DATA_BW;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_BW-1:0]  r_addr;
    logic [LEN_BW-1:0]   r_rd_left;
    logic [LEN_BW-1:0]   r_beat_left;
    logic                r_inflight;
    logic                r_done;
    logic                w_r_en;
    logic                w_pop;
    logic                w_accept;
    logic [1:0]          w_count;
    logic [1:0]          w_occ;
    logic                w_valid;
    logic [FIFO_W-1:0]   w_push_data;
    logic [FIFO_W-1:0]   w_head;

`ifdef BRAM_RD_TLAST_EN
    logic                r_inflight_last;
    assign w_push_data  = {r_inflight_last, i_r_data};
    assign m_axis_tlast = w_valid && w_head[DATA_BW];
`else
    assign w_push_data  = i_r_data;
`endif

    assign w_pop         = w_valid && m_axis_tready;
    assign w_accept      = (r_state == ST_IDLE) && i_start && (i_len != '0);
    assign w_occ         = w_count + {1'b0, r_inflight};
    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_head[DATA_BW-1:0];
    assign o_r_en        = w_r_en;
    assign o_r_addr      = r_addr;
    assign o_done        = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_RUN;
            ST_RUN:   if (w_r_en && r_rd_left == LEN_BW'(1)) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_pop && r_beat_left == LEN_BW'(1)) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // A beat leaving this cycle frees its slot, which keeps reads flowing at one per cycle.
    always_comb begin
        o_busy = (r_state != ST_IDLE);
        w_r_en = (r_state == ST_RUN) && ((w_occ - {1'b0, w_pop}) < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_rd_left   <= '0;
            r_beat_left <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_r_en;
            r_done     <= ((r_state == ST_IDLE) && i_start && (i_len == '0)) ||
                          ((r_state == ST_DRAIN) && w_pop && (r_beat_left == LEN_BW'(1)));
            if (w_accept) begin
                r_addr      <= i_base_addr;
                r_rd_left   <= i_len;
                r_beat_left <= i_len;
            end else begin
                if (w_r_en) begin
                    r_addr    <= r_addr + ADDR_BW'(STRIDE);
                    r_rd_left <= r_rd_left - LEN_BW'(1);
                end
                if (w_pop) begin
                    r_beat_left <= r_beat_left - LEN_BW'(1);
                end
            end
        end
    end

`ifdef BRAM_RD_TLAST_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight_last <= w_r_en && (r_rd_left == LEN_BW'(1));
        end
    end
`endif

    bram_rd_skid #(
        .W (FIFO_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_valid     (w_valid),
        .o_data      (w_head),
        .o_count     (w_count)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: stimulus queues expected reads/beats,
// a negedge monitor compares them. Define BRAM_RD_TLAST_EN to also check tlast.
module tb_bram_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iStart = 1'b0;
   logic [9:0]  iBaseAddr = '0;
   logic [15:0] iLen = '0;
   logic        oBusy;
   logic        oDone;
   logic        oREn;
   logic [9:0]  oRAddr;
   logic [31:0] iRData = '0;
   logic        tValid;
   logic        tReady = 1'b0;
   logic [31:0] tData;
   logic        tLast;

   int testsRun = 0;
   int testsFailed = 0;
   int doneCount = 0;
   int beatCount = 0;
   int pending = 0;
   logic        prevStall = 1'b0;
   logic [31:0] prevData = '0;

   logic [9:0]  expAddr[$];
   logic [32:0] expBeat[$];

   always #5 clk = ~clk;

   bram_stream_reader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (iStart),
      .i_base_addr   (iBaseAddr),
      .i_len         (iLen),
      .o_busy        (oBusy),
      .o_done        (oDone),
      .o_r_en        (oREn),
      .o_r_addr      (oRAddr),
      .i_r_data      (iRData),
      .m_axis_tvalid (tValid),
      .m_axis_tready (tReady),
      .m_axis_tdata  (tData)
`ifdef BRAM_RD_TLAST_EN
     ,.m_axis_tlast  (tLast)
`endif
   );

`ifndef BRAM_RD_TLAST_EN
   assign tLast = 1'b0;
`endif

   // Memory model: one-cycle read latency, contents derived from the byte address.
   always @(posedge clk) begin
      if (oREn) iRData <= 32'hC0DE_0000 | {22'd0, oRAddr};
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT issues a read or hands off a beat.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevStall = 1'b0;
         pending = 0;
      end else begin
         if (prevStall) begin
            checkOutput("stallValidHeld", {63'd0, tValid}, 64'd1);
            checkOutput("stallDataStable", {32'd0, tData}, {32'd0, prevData});
         end
         if (oBusy) checkOutput("outstandingLe2", {63'd0, pending <= 2}, 64'd1);
         if (oREn) begin
            if (expAddr.size() == 0) checkOutput("unexpectedRead", {54'd0, oRAddr}, 64'hFFFF);
            else checkOutput("readAddr", {54'd0, oRAddr}, {54'd0, expAddr.pop_front()});
            pending++;
         end
         if (tValid && tReady) begin
            if (expBeat.size() == 0) begin
               checkOutput("unexpectedBeat", {32'd0, tData}, 64'hFFFF_FFFF_FFFF);
            end else begin
               logic [32:0] e;
               e = expBeat.pop_front();
               checkOutput("beatData", {32'd0, tData}, {32'd0, e[31:0]});
`ifdef BRAM_RD_TLAST_EN
               checkOutput("beatLast", {63'd0, tLast}, {63'd0, e[32]});
`endif
            end
            pending--;
            beatCount++;
         end
         if (oDone) doneCount++;
         prevStall = tValid && !tReady;
         prevData = tData;
      end
   end

   task automatic pushExpected(input logic [9:0] base, input int len);
      for (int k = 0; k < len; k++) begin
         logic [9:0] a;
         a = base + 10'(4 * k);
         expAddr.push_back(a);
         expBeat.push_back({k == len - 1, 32'hC0DE_0000 | {22'd0, a}});
      end
   endtask

   task automatic applyStimulus(input logic [9:0] base, input logic [15:0] len);
      iBaseAddr = base;
      iLen = len;
      iStart = 1'b1;
      @(posedge clk);
      #1;
      iStart = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      while (oDone !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_doneSeen"}, {63'd0, oDone}, 64'd1);
   endtask

   task automatic checkDrained(input string name);
      checkOutput({name, "_addrQEmpty"}, 64'(expAddr.size()), 64'd0);
      checkOutput({name, "_beatQEmpty"}, 64'(expBeat.size()), 64'd0);
   endtask

   initial begin
      logic [6:0] expEn, expVal, expDn, expBsy;
      logic [3:0] readyPat;
      int d0;
      int n;

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("resetBusy", {63'd0, oBusy}, 64'd0);
      checkOutput("resetDone", {63'd0, oDone}, 64'd0);
      checkOutput("resetREn", {63'd0, oREn}, 64'd0);
      checkOutput("resetTValid", {63'd0, tValid}, 64'd0);
      checkOutput("resetRAddr", {54'd0, oRAddr}, 64'd0);
      rst_n = 1'b1;
      tReady = 1'b1;
      @(posedge clk);
      #1;

      // base 0x010, len 4: reads in cycles 1-4, beats 3-6, done in cycle 7
      expAddr.push_back(10'h010); expAddr.push_back(10'h014);
      expAddr.push_back(10'h018); expAddr.push_back(10'h01C);
      expBeat.push_back({1'b0, 32'hC0DE_0010}); expBeat.push_back({1'b0, 32'hC0DE_0014});
      expBeat.push_back({1'b0, 32'hC0DE_0018}); expBeat.push_back({1'b1, 32'hC0DE_001C});
      expEn  = 7'b0001111;
      expVal = 7'b0111100;
      expDn  = 7'b1000000;
      expBsy = 7'b0111111;
      applyStimulus(10'h010, 16'd4);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         checkOutput($sformatf("t1_rEn_c%0d", c + 1), {63'd0, oREn}, {63'd0, expEn[c]});
         checkOutput($sformatf("t1_tvalid_c%0d", c + 1), {63'd0, tValid}, {63'd0, expVal[c]});
         checkOutput($sformatf("t1_done_c%0d", c + 1), {63'd0, oDone}, {63'd0, expDn[c]});
         checkOutput($sformatf("t1_busy_c%0d", c + 1), {63'd0, oBusy}, {63'd0, expBsy[c]});
      end
      checkDrained("t1");
      @(posedge clk);
      #1;

      // Wrapping addresses, then a new start issued in the done cycle
      expAddr.push_back(10'h3F8); expAddr.push_back(10'h3FC);
      expAddr.push_back(10'h000); expAddr.push_back(10'h004);
      expBeat.push_back({1'b0, 32'hC0DE_03F8}); expBeat.push_back({1'b0, 32'hC0DE_03FC});
      expBeat.push_back({1'b0, 32'hC0DE_0000}); expBeat.push_back({1'b1, 32'hC0DE_0004});
      applyStimulus(10'h3F8, 16'd4);
      waitDone("t2");
      checkOutput("t2_busyLowAtDone", {63'd0, oBusy}, 64'd0);
      pushExpected(10'h080, 2);
      applyStimulus(10'h080, 16'd2);
      @(negedge clk);
      checkOutput("t2b_busyAfterStartInDone", {63'd0, oBusy}, 64'd1);
      waitDone("t2b");
      checkDrained("t2");
      @(posedge clk);
      #1;

      // len 8 with backpressure pattern 1,0,0,1
      readyPat = 4'b1001;
      d0 = doneCount;
      pushExpected(10'h100, 8);
      applyStimulus(10'h100, 16'd8);
      n = 0;
      while (doneCount == d0 && n < 200) begin
         tReady = readyPat[n % 4];
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("t3_doneSeen", 64'(doneCount - d0), 64'd1);
      checkDrained("t3");
      tReady = 1'b1;

      // len 0: done next cycle, never busy, no reads
      @(posedge clk);
      #1;
      applyStimulus(10'h050, 16'd0);
      @(negedge clk);
      checkOutput("t4_done", {63'd0, oDone}, 64'd1);
      checkOutput("t4_busy", {63'd0, oBusy}, 64'd0);
      checkOutput("t4_rEn", {63'd0, oREn}, 64'd0);
      @(negedge clk);
      checkOutput("t4_doneOneCycle", {63'd0, oDone}, 64'd0);
      checkOutput("t4_busyStillLow", {63'd0, oBusy}, 64'd0);
      @(posedge clk);
      #1;

      // Reset after the second beat of a len 6 transfer
      d0 = doneCount;
      n = beatCount;
      pushExpected(10'h200, 6);
      applyStimulus(10'h200, 16'd6);
      for (int c = 0; c < 50 && beatCount < n + 2; c++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("t5_twoBeats", 64'(beatCount - n), 64'd2);
      rst_n = 1'b0;
      tReady = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expAddr.delete();
      expBeat.delete();
      @(negedge clk);
      checkOutput("t5_busy", {63'd0, oBusy}, 64'd0);
      checkOutput("t5_done", {63'd0, oDone}, 64'd0);
      checkOutput("t5_rEn", {63'd0, oREn}, 64'd0);
      checkOutput("t5_tvalid", {63'd0, tValid}, 64'd0);
      checkOutput("t5_rAddr", {54'd0, oRAddr}, 64'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("t5_noTValidAfter", {63'd0, tValid}, 64'd0);
      end
      checkOutput("t5_noDone", 64'(doneCount - d0), 64'd0);
      tReady = 1'b1;
      @(posedge clk);
      #1;
      pushExpected(10'h020, 2);
      applyStimulus(10'h020, 16'd2);
      waitDone("t5b");
      checkDrained("t5b");
      @(posedge clk);
      #1;

      // len 3 (tlast on beat 3 when enabled) with an ignored start while busy
      d0 = doneCount;
      pushExpected(10'h040, 3);
      applyStimulus(10'h040, 16'd3);
      iBaseAddr = 10'h300;
      iLen = 16'd5;
      iStart = 1'b1;
      @(posedge clk);
      #1;
      iStart = 1'b0;
      waitDone("t6");
      repeat (4) @(negedge clk);
      checkOutput("t6_oneDone", 64'(doneCount - d0), 64'd1);
      checkOutput("t6_idleAfter", {63'd0, oBusy}, 64'd0);
      checkDrained("t6");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
